bcd_scan_display: RTL

Time-multiplexed 7-segment driver for the ALU result path. It takes the 12-bit three-digit BCD value produced by the binary-to-BCD converter, plus a sign flag, and scans it onto a 4-digit common-anode display: sign, hundreds, tens, ones. Updates are double-buffered so a new value only appears at a frame boundary, which prevents torn digits. It also applies leading-zero blanking, an inter-digit ghosting guard and invalid-digit flagging.

---
 rtl/bcd_scan_display_pkg.sv | 26 ++
 rtl/bcd_scan_display_bcd_to_seg.sv | 27 ++
 rtl/bcd_scan_display.sv | 129 ++++++++++++
 3 files changed

// File: rtl/bcd_scan_display_pkg.sv
// Shared constants for the BCD scan display: active-high segment patterns
// ({g,f,e,d,c,b,a}) and the digit slot enumeration.
package bcd_scan_display_pkg;

  localparam logic [6:0] SEG_0    = 7'h3F;
  localparam logic [6:0] SEG_1    = 7'h06;
  localparam logic [6:0] SEG_2    = 7'h5B;
  localparam logic [6:0] SEG_3    = 7'h4F;
  localparam logic [6:0] SEG_4    = 7'h66;
  localparam logic [6:0] SEG_5    = 7'h6D;
  localparam logic [6:0] SEG_6    = 7'h7D;
  localparam logic [6:0] SEG_7    = 7'h07;
  localparam logic [6:0] SEG_8    = 7'h7F;
  localparam logic [6:0] SEG_9    = 7'h6F;
  localparam logic [6:0] SEG_DASH = 7'h40;
  localparam logic [6:0] SEG_E    = 7'h79;
  localparam logic [6:0] SEG_OFF  = 7'h00;

  typedef enum logic [1:0] {
    SLOT_ONES = 2'd0,
    SLOT_TENS = 2'd1,
    SLOT_HUND = 2'd2,
    SLOT_SIGN = 2'd3
  } slot_e;

endpackage

// File: rtl/bcd_scan_display_bcd_to_seg.sv
// Combinational BCD nibble to active-high 7-segment pattern; any value above
// 9 renders as "E" so a corrupt converter output is visible on the display.
module bcd_to_seg
  import bcd_scan_display_pkg::*;
(
  input  logic [3:0] nibble_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_E;
    case (nibble_i)
      4'd0: seg_o = SEG_0;
      4'd1: seg_o = SEG_1;
      4'd2: seg_o = SEG_2;
      4'd3: seg_o = SEG_3;
      4'd4: seg_o = SEG_4;
      4'd5: seg_o = SEG_5;
      4'd6: seg_o = SEG_6;
      4'd7: seg_o = SEG_7;
      4'd8: seg_o = SEG_8;
      4'd9: seg_o = SEG_9;
      default: seg_o = SEG_E;
    endcase
  end

endmodule

// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed 7-segment driver (sign, hundreds, tens, ones) with a
// double-buffered value that only changes at frame boundaries.
module bcd_scan_display
  import bcd_scan_display_pkg::*;
#(
  parameter int PRESCALE   = 50000,
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] bcd,
  input  logic        neg,
  input  logic        load,
  input  logic        blank,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        pend,
  output logic        frame
);

  localparam int CNT_W = $clog2(PRESCALE);
  localparam logic [6:0] SEG_IDLE = ACTIVE_LOW ? ~SEG_OFF : SEG_OFF;
  localparam logic [3:0] AN_IDLE  = ACTIVE_LOW ? 4'hF : 4'h0;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  slot_e            idx_q, idx_d;
  logic [11:0]      disp_bcd_q, disp_bcd_d;
  logic             disp_neg_q, disp_neg_d;
  logic [11:0]      shd_bcd_q, shd_bcd_d;
  logic             shd_neg_q, shd_neg_d;
  logic             pend_q, pend_d;
  logic             frame_q, frame_d;
  logic [6:0]       seg_q, seg_d;
  logic [3:0]       an_q, an_d;

  logic             tick;
  logic             boundary;
  logic [6:0]       digit_pat [3];
  logic [6:0]       pat;
  logic             slot_on;
  logic [3:0]       an_act;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dec
    bcd_to_seg u_dec (
      .nibble_i (disp_bcd_q[4*gi +: 4]),
      .seg_o    (digit_pat[gi])
    );
  end

  assign tick     = (cnt_q == CNT_W'(PRESCALE - 1));
  assign boundary = tick && (idx_q == SLOT_SIGN);

  always_comb begin
    cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
    idx_d      = tick ? slot_e'(idx_q + 2'd1) : idx_q;
    frame_d    = boundary;
    disp_bcd_d = disp_bcd_q;
    disp_neg_d = disp_neg_q;
    shd_bcd_d  = shd_bcd_q;
    shd_neg_d  = shd_neg_q;
    pend_d     = pend_q;

    // A load landing on the boundary bypasses the shadow entirely.
    if (boundary) begin
      if (load) begin
        disp_bcd_d = bcd;
        disp_neg_d = neg;
        pend_d     = 1'b0;
      end else if (pend_q) begin
        disp_bcd_d = shd_bcd_q;
        disp_neg_d = shd_neg_q;
        pend_d     = 1'b0;
      end
    end else if (load) begin
      shd_bcd_d = bcd;
      shd_neg_d = neg;
      pend_d    = 1'b1;
    end
  end

  // An invalid nibble is nonzero, so it naturally keeps lower digits lit.
  always_comb begin
    slot_on = 1'b0;
    pat     = SEG_OFF;
    case (idx_q)
      SLOT_ONES: begin slot_on = 1'b1;                            pat = digit_pat[0]; end
      SLOT_TENS: begin slot_on = (disp_bcd_q[11:4] != 8'd0);      pat = digit_pat[1]; end
      SLOT_HUND: begin slot_on = (disp_bcd_q[11:8] != 4'd0);      pat = digit_pat[2]; end
      SLOT_SIGN: begin slot_on = disp_neg_q;                      pat = SEG_DASH;     end
      default:   begin slot_on = 1'b0;                            pat = SEG_OFF;      end
    endcase
    if (!slot_on) pat = SEG_OFF;
    an_act = (slot_on && !blank && (cnt_q != '0)) ? (4'b0001 << idx_q) : 4'b0000;
    seg_d  = ACTIVE_LOW ? ~pat : pat;
    an_d   = ACTIVE_LOW ? ~an_act : an_act;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q      <= '0;
      idx_q      <= SLOT_ONES;
      disp_bcd_q <= '0;
      disp_neg_q <= 1'b0;
      shd_bcd_q  <= '0;
      shd_neg_q  <= 1'b0;
      pend_q     <= 1'b0;
      frame_q    <= 1'b0;
      seg_q      <= SEG_IDLE;
      an_q       <= AN_IDLE;
    end else begin
      cnt_q      <= cnt_d;
      idx_q      <= idx_d;
      disp_bcd_q <= disp_bcd_d;
      disp_neg_q <= disp_neg_d;
      shd_bcd_q  <= shd_bcd_d;
      shd_neg_q  <= shd_neg_d;
      pend_q     <= pend_d;
      frame_q    <= frame_d;
      seg_q      <= seg_d;
      an_q       <= an_d;
    end
  end

  assign seg   = seg_q;
  assign an    = an_q;
  assign pend  = pend_q;
  assign frame = frame_q;

endmodule
